// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the RV32I 5-stage pipeline with a data-memory wait FSM.
// Optional perf counters (o_stall_cnt, o_flush_cnt) enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [4:0] i_rs1_addrD,
  input  logic [4:0] i_rs2_addrD,
  input  logic [4:0] i_rs1_addrE,
  input  logic [4:0] i_rs2_addrE,
  input  logic [4:0] i_rd_addrE,
  input  logic [1:0] i_result_srcE,
  input  logic       i_pc_srcE,
  input  logic [4:0] i_rd_addrM,
  input  logic       i_reg_wr_enM,
  input  logic [4:0] i_rd_addrW,
  input  logic       i_reg_wr_enW,
  input  logic       i_dmem_reqM,
  input  logic       i_dmem_ready,
  output logic       o_stallF,
  output logic       o_stallD,
  output logic       o_flushD,
  output logic       o_stallE,
  output logic       o_flushE,
  output logic       o_stallM,
  output logic [1:0] o_fwd_rs1E,
  output logic [1:0] o_fwd_rs2E,
  output logic       o_dmem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  logic       lw_stall;
  logic       stall_fd, stall_em, flush_d, flush_e;
  logic [1:0] fwd1, fwd2;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                          return 2'b00;
  endfunction

  always_comb begin
    fwd1 = fwd_sel(i_rs1_addrE, i_rd_addrM, i_reg_wr_enM, i_rd_addrW, i_reg_wr_enW);
    fwd2 = fwd_sel(i_rs2_addrE, i_rd_addrM, i_reg_wr_enM, i_rd_addrW, i_reg_wr_enW);
  end

  assign lw_stall = (i_result_srcE == 2'b01) && (i_rd_addrE != 5'd0) &&
                    (i_rd_addrE == i_rs1_addrD || i_rd_addrE == i_rs2_addrD);

  // A taken branch squashes the load-use stall: the stalled instruction is on the wrong path.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_fd   = lw_stall & ~i_pc_srcE;
    stall_em   = 1'b0;
    flush_d    = i_pc_srcE;
    flush_e    = lw_stall | i_pc_srcE;
    case (state_q)
      RUN: begin
        if (i_dmem_reqM && !i_dmem_ready) begin
          stall_fd   = 1'b1;
          stall_em   = 1'b1;
          flush_d    = 1'b0;
          flush_e    = 1'b0;
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (i_dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          stall_fd = 1'b1;
          stall_em = 1'b1;
          flush_d  = 1'b0;
          flush_e  = 1'b0;
          if (wait_cnt_q == CNT_W'(WAIT_MAX)) begin
            state_d   = ERR;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        stall_fd = 1'b1;
        stall_em = 1'b1;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs are forced quiet while reset is held, whatever the inputs are doing.
  assign o_stallF       = i_rstn & stall_fd;
  assign o_stallD       = i_rstn & stall_fd;
  assign o_stallE       = i_rstn & stall_em;
  assign o_stallM       = i_rstn & stall_em;
  assign o_flushD       = i_rstn & flush_d;
  assign o_flushE       = i_rstn & flush_e;
  assign o_fwd_rs1E     = i_rstn ? fwd1 : 2'b00;
  assign o_fwd_rs2E     = i_rstn ? fwd2 : 2'b00;
  assign o_dmem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_stallF && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (o_flushE && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (WAIT_MAX=4); perf counters checked when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0] rsrc;
  logic       pcsrc, wrM, wrW, req, rdy;
  logic       stallF, stallD, flushD, stallE, flushE, stallM, tmo;
  logic [1:0] f1, f2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] scnt, fcnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WAIT_MAX(4), .CNT_W(8)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_rs1_addrD(rs1D), .i_rs2_addrD(rs2D), .i_rs1_addrE(rs1E), .i_rs2_addrE(rs2E),
    .i_rd_addrE(rdE), .i_result_srcE(rsrc), .i_pc_srcE(pcsrc),
    .i_rd_addrM(rdM), .i_reg_wr_enM(wrM), .i_rd_addrW(rdW), .i_reg_wr_enW(wrW),
    .i_dmem_reqM(req), .i_dmem_ready(rdy),
    .o_stallF(stallF), .o_stallD(stallD), .o_flushD(flushD), .o_stallE(stallE),
    .o_flushE(flushE), .o_stallM(stallM), .o_fwd_rs1E(f1), .o_fwd_rs2E(f2),
    .o_dmem_timeout(tmo)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
`endif
  );

  // ctl = {stallF, stallD, flushD, stallE, flushE, stallM}
  typedef struct {
    int rs1D, rs2D, rs1E, rs2E, rdE, rsrc, pcsrc, rdM, wrM, rdW, wrW, req, rdy;
    int ctl, f1, f2;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return 32'({stallF, stallD, flushD, stallE, flushE, stallM});
  endfunction

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rsrc = 0; pcsrc = 0;
    rdM = 0; wrM = 0; rdW = 0; wrW = 0; req = 0; rdy = 0;
  endtask

  task automatic lw_hazard();
    idle(); rsrc = 2'b01; rdE = 5'd7; rs2D = 5'd7;
  endtask

  initial begin
    vecs[0]  = '{0,0,5,0,0,0,0, 5,1,5,1, 0,0, 'b000000, 'b10, 'b00};
    vecs[1]  = '{0,0,5,0,0,0,0, 5,0,5,1, 0,0, 'b000000, 'b01, 'b00};
    vecs[2]  = '{0,0,0,0,0,0,0, 0,1,0,1, 0,0, 'b000000, 'b00, 'b00};
    vecs[3]  = '{0,0,3,9,0,0,0, 3,1,9,1, 0,0, 'b000000, 'b10, 'b01};
    vecs[4]  = '{0,7,0,0,7,1,0, 0,0,0,0, 0,0, 'b110010, 'b00, 'b00};
    vecs[5]  = '{0,0,0,0,0,1,0, 0,0,0,0, 0,0, 'b000000, 'b00, 'b00};
    vecs[6]  = '{7,0,0,0,7,0,0, 0,0,0,0, 0,0, 'b000000, 'b00, 'b00};
    vecs[7]  = '{12,0,0,0,12,1,0, 0,0,0,0, 0,0, 'b110010, 'b00, 'b00};
    vecs[8]  = '{0,0,0,0,0,0,1, 0,0,0,0, 0,0, 'b001010, 'b00, 'b00};
    vecs[9]  = '{0,7,0,0,7,1,1, 0,0,0,0, 0,0, 'b001010, 'b00, 'b00};
    vecs[10] = '{0,0,0,0,0,0,0, 0,0,0,0, 1,1, 'b000000, 'b00, 'b00};
    vecs[11] = '{0,7,0,0,7,1,0, 0,0,0,0, 1,1, 'b110010, 'b00, 'b00};
    vecs[12] = '{0,0,4,6,0,0,0, 6,1,4,1, 0,0, 'b000000, 'b01, 'b10};
    vecs[13] = '{7,0,8,0,7,2,0, 0,0,8,0, 0,0, 'b000000, 'b00, 'b00};

    idle();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    // Inputs that would stall, flush and forward must all be masked by reset.
    lw_hazard(); pcsrc = 1; req = 1; rs1E = 5'd5; rdM = 5'd5; wrM = 1;
    #1;
    chk("reset_ctl", ctl(), 0);
    chk("reset_fwd1", 32'(f1), 0);
    chk("reset_tmo", 32'(tmo), 0);
    @(negedge clk);
    idle();
    rstn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rs1D = 5'(vecs[i].rs1D); rs2D = 5'(vecs[i].rs2D);
      rs1E = 5'(vecs[i].rs1E); rs2E = 5'(vecs[i].rs2E);
      rdE = 5'(vecs[i].rdE); rsrc = 2'(vecs[i].rsrc); pcsrc = 1'(vecs[i].pcsrc);
      rdM = 5'(vecs[i].rdM); wrM = 1'(vecs[i].wrM);
      rdW = 5'(vecs[i].rdW); wrW = 1'(vecs[i].wrW);
      req = 1'(vecs[i].req); rdy = 1'(vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_ctl", i), ctl(), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_fwd1", i), 32'(f1), 32'(vecs[i].f1));
      chk($sformatf("vec%0d_fwd2", i), 32'(f2), 32'(vecs[i].f2));
    end

    // Load-use stall lasts only while the hazard is present.
    @(negedge clk); lw_hazard(); #1;
    chk("lu_on", ctl(), 'b110010);
    @(negedge clk); idle(); #1;
    chk("lu_off", ctl(), 0);

    // Memory wait: 3 stalled cycles with a branch pending, then ready.
    @(negedge clk); idle(); pcsrc = 1; req = 1; rdy = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      chk($sformatf("mw_stall%0d", c), ctl(), 'b110101);
    end
    @(negedge clk); rdy = 1; #1;
    chk("mw_ready", ctl(), 'b001010);
    @(negedge clk); idle(); #1;
    chk("mw_back_run", ctl(), 0);
    chk("mw_no_tmo", 32'(tmo), 0);

    // Timeout: five stalled cycles, then sticky error.
    @(negedge clk); idle(); req = 1; rdy = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      chk($sformatf("to_stall%0d", c), ctl(), 'b110101);
      chk($sformatf("to_tmo_low%0d", c), 32'(tmo), 0);
    end
    @(negedge clk); #1;
    chk("to_tmo_high", 32'(tmo), 1);
    @(negedge clk); req = 0; rdy = 1; pcsrc = 1; #1;
    chk("to_err_ctl", ctl(), 'b110101);
    @(negedge clk); #1;
    chk("to_sticky", 32'(tmo), 1);
    rstn = 1'b0; #1;
    chk("to_async_clr", 32'(tmo), 0);
    chk("to_async_ctl", ctl(), 0);
    @(negedge clk); idle(); rstn = 1'b1; #1;
    chk("to_after_rst", ctl(), 0);

    // Reset in the middle of a memory wait.
    @(negedge clk); req = 1; rdy = 0;
    @(negedge clk); #1;
    chk("rmw_wait", ctl(), 'b110101);
    rstn = 1'b0; #1;
    chk("rmw_rst_ctl", ctl(), 0);
    @(negedge clk); idle(); rstn = 1'b1; #1;
    chk("rmw_run", ctl(), 0);

    // Two load-use stalls and one branch since the last reset.
    @(negedge clk); lw_hazard();
    @(negedge clk); idle();
    @(negedge clk); lw_hazard();
    @(negedge clk); idle();
    @(negedge clk); pcsrc = 1;
    @(negedge clk); idle(); #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_cnt", scnt, 2);
    chk("perf_flush_cnt", fcnt, 3);
`endif
    chk("final_idle", ctl(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
